// File: rtl/score_event_arbiter.sv
// Purpose : serialise per-requester hit events into gapped single-cycle score_inc pulses; sequence score_clr.
// Latency : hit sampled at edge k, grant at edge k+1, score_inc high for the cycle after edge k+1.
// Backpressure: none upstream; hits queue in saturating per-requester counters, excess sets sticky overflow.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   enable    game running: hits accepted and grants issued only while high
//   clear     synchronous one-cycle request to clear score and all pending state
//   hit_req   per-requester hit pulse, one point per high cycle
//   score_inc one-cycle increment pulse to the scoreboard (at least GAP low cycles between pulses)
//   score_clr one-cycle reset pulse to the scoreboard
//   grant_id  requester served by the current or last pulse
//   busy      FSM not idle or any pending hit outstanding
//   overflow  sticky per-requester flag: a hit was dropped at counter saturation
//
// Build option: define FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module score_event_arbiter #(
    parameter int N_REQ  = 4,
    parameter int PEND_W = 3,
    parameter int GAP    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [N_REQ-1:0]         hit_req,
    output logic                     score_inc,
    output logic                     score_clr,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [N_REQ-1:0]         overflow
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP,
        ST_CLR
    } state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [PEND_W-1:0]  pend_q [N_REQ];
    logic [PEND_W-1:0]  pend_d [N_REQ];
    logic [N_REQ-1:0]   ovf_d;
    logic [N_REQ-1:0]   pend_nz;
    logic [N_REQ-1:0]   acc;
    logic [N_REQ-1:0]   take;
    logic               grant;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pend_nz[i] = |pend_q[i];
        end
    end

    // Requester selection among nonzero pending counters.
`ifdef FIXED_PRIO_EN
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        // Scan downwards so the lowest nonzero index is the last to be written.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pend_nz[k]) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] cand;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        // Search starts one past the last winner and wraps, so the last winner is checked last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!sel_vld && pend_nz[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (clear) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (grant) begin
            last_grant <= sel_idx;
        end
    end
`endif

    // Next-state logic; clear overrides everything, including an in-flight pulse.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && sel_vld) begin
                    grant   = 1'b1;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                state_d = ST_GAP;
                gap_d   = GAP_W'(GAP);
            end
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_CLR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_d = ST_CLR;
            grant   = 1'b0;
        end
    end

    assign acc = enable ? hit_req : '0;

    always_comb begin
        take = '0;
        if (grant) begin
            take[sel_idx] = 1'b1;
        end
    end

    // Pending counters: a simultaneous hit and grant on one requester cancel out,
    // so a saturated counter being served never drops its hit.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            pend_d[i] = pend_q[i];
            ovf_d[i]  = overflow[i];
            if (clear) begin
                pend_d[i] = '0;
                ovf_d[i]  = 1'b0;
            end else if (acc[i] && !take[i]) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_W'(1);
                end
            end else if (!acc[i] && take[i]) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            grant_id <= '0;
            overflow <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            overflow <= ovf_d;
            if (grant) begin
                grant_id <= sel_idx;
            end
            for (int i = 0; i < N_REQ; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    // Outputs decode the registered state only, so they cannot glitch or overlap.
    assign score_inc = (state_q == ST_PULSE);
    assign score_clr = (state_q == ST_CLR);
    assign busy      = (state_q != ST_IDLE) || (|pend_nz);

endmodule

// File: tb/tb_score_event_arbiter.sv
// Bench for score_event_arbiter: fixed vector table, hand sequences for reset/clear/saturation/ordering,
// and randomized traffic checked every cycle against a timestamp-based reference model.
module tb_score_event_arbiter;

    localparam int N_REQ  = 4;
    localparam int PEND_W = 3;
    localparam int GAP    = 1;
    localparam int PMAX   = (1 << PEND_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear;
    logic [3:0] hit_req;
    logic       score_inc;
    logic       score_clr;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] overflow;

    always #5 clk = ~clk;

    score_event_arbiter #(
        .N_REQ (N_REQ),
        .PEND_W(PEND_W),
        .GAP   (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (clear),
        .hit_req  (hit_req),
        .score_inc(score_inc),
        .score_clr(score_clr),
        .grant_id (grant_id),
        .busy     (busy),
        .overflow (overflow)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pending counts plus timestamps of the last grant / clear and
    // the edge after which the arbiter is idle again.
    int         m_pend [N_REQ];
    logic [3:0] m_ovf;
    int         m_last, m_gid, edge_n, grant_edge, clr_edge, idle_after;
    int         exp_pulses, dut_pulses;
    int         gq[$];

    function automatic void model_reset();
        for (int i = 0; i < N_REQ; i++) m_pend[i] = 0;
        m_ovf      = '0;
        m_last     = N_REQ - 1;
        m_gid      = 0;
        edge_n     = 0;
        grant_edge = -100;
        clr_edge   = -100;
        idle_after = 0;
    endfunction

    function automatic void model_edge(input logic en, input logic clr, input logic [3:0] hit);
        int sel;
        edge_n++;
        if (clr) begin
            for (int i = 0; i < N_REQ; i++) m_pend[i] = 0;
            m_ovf      = '0;
            m_last     = N_REQ - 1;
            clr_edge   = edge_n;
            idle_after = edge_n + 1;
        end else begin
            sel = -1;
`ifdef FIXED_PRIO_EN
            for (int k = 0; k < N_REQ; k++)
                if (sel < 0 && m_pend[k] > 0) sel = k;
`else
            for (int k = 1; k <= N_REQ; k++)
                if (sel < 0 && m_pend[(m_last + k) % N_REQ] > 0) sel = (m_last + k) % N_REQ;
`endif
            if (edge_n - 1 >= idle_after && en && sel >= 0) begin
                m_pend[sel]--;
                m_gid      = sel;
                m_last     = sel;
                grant_edge = edge_n;
                idle_after = edge_n + GAP + 1;
                exp_pulses++;
            end
            if (en) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (hit[i]) begin
                        if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
                        else m_pend[i]++;
                    end
                end
            end
        end
    endfunction

    function automatic logic [8:0] model_out();
        logic any;
        any = 1'b0;
        for (int i = 0; i < N_REQ; i++) if (m_pend[i] != 0) any = 1'b1;
        return {edge_n == grant_edge, edge_n == clr_edge, 2'(m_gid),
                (edge_n < idle_after) || any, m_ovf};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [8:0] act, exp;
        act = {score_inc, score_clr, grant_id, busy, overflow};
        exp = model_out();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL model@edge%0d {inc,clr,gid,busy,ovf}: got %b, expected %b", edge_n, act, exp);
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic en, input logic clr, input logic [3:0] hit);
        enable  = en;
        clear   = clr;
        hit_req = hit;
        @(posedge clk);
        model_edge(en, clr, hit);
        @(negedge clk);
        if (score_inc === 1'b1) begin
            dut_pulses++;
            gq.push_back(int'(grant_id));
        end
        check_model();
    endtask

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] hit;
        logic [8:0] exp;   // {inc, clr, gid[1:0], busy, ovf[3:0]}
    } vec_t;

    function automatic vec_t mkv(input int en, input int clr, input int hit,
                                 input int inc, input int sclr, input int gid, input int bsy);
        vec_t v;
        v.en  = 1'(en);
        v.clr = 1'(clr);
        v.hit = 4'(hit);
        v.exp = {1'(inc), 1'(sclr), 2'(gid), 1'(bsy), 4'h0};
        return v;
    endfunction

    vec_t tbl [19];

    initial begin
        int p0, e0;
        int exp_order [4];

        reset   = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        hit_req = '0;
        exp_pulses = 0;
        dut_pulses = 0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check("reset score_inc", 32'(score_inc), 0);
        check("reset score_clr", 32'(score_clr), 0);
        check("reset grant_id", 32'(grant_id), 0);
        check("reset busy", 32'(busy), 0);
        check("reset overflow", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;

        // 4'b1111 after reset: grants 0,1,2,3 three cycles apart; then one hit on 0; then a clear.
        tbl[0]  = mkv(1, 0, 15, 0, 0, 0, 1);
        tbl[1]  = mkv(1, 0, 0,  1, 0, 0, 1);
        tbl[2]  = mkv(1, 0, 0,  0, 0, 0, 1);
        tbl[3]  = mkv(1, 0, 0,  0, 0, 0, 1);
        tbl[4]  = mkv(1, 0, 0,  1, 0, 1, 1);
        tbl[5]  = mkv(1, 0, 0,  0, 0, 1, 1);
        tbl[6]  = mkv(1, 0, 0,  0, 0, 1, 1);
        tbl[7]  = mkv(1, 0, 0,  1, 0, 2, 1);
        tbl[8]  = mkv(1, 0, 0,  0, 0, 2, 1);
        tbl[9]  = mkv(1, 0, 0,  0, 0, 2, 1);
        tbl[10] = mkv(1, 0, 0,  1, 0, 3, 1);
        tbl[11] = mkv(1, 0, 0,  0, 0, 3, 1);
        tbl[12] = mkv(1, 0, 0,  0, 0, 3, 0);
        tbl[13] = mkv(1, 0, 1,  0, 0, 3, 1);
        tbl[14] = mkv(1, 0, 0,  1, 0, 0, 1);
        tbl[15] = mkv(1, 0, 0,  0, 0, 0, 1);
        tbl[16] = mkv(1, 0, 0,  0, 0, 0, 0);
        tbl[17] = mkv(1, 1, 0,  0, 1, 0, 1);
        tbl[18] = mkv(1, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].hit);
            check($sformatf("table row %0d", i),
                  32'({score_inc, score_clr, grant_id, busy, overflow}), 32'(tbl[i].exp));
        end

        // Two hits on requesters 1 and 3 right after a clear: grant order depends on arbitration mode.
`ifdef FIXED_PRIO_EN
        exp_order = '{1, 1, 3, 3};
`else
        exp_order = '{1, 3, 1, 3};
`endif
        gq.delete();
        step(1, 0, 4'b1010);
        step(1, 0, 4'b1010);
        repeat (14) step(1, 0, 4'b0000);
        check("order pulse count", gq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < gq.size()) check($sformatf("order grant %0d", i), gq[i], exp_order[i]);
        end

        // Hits while disabled are ignored.
        p0 = dut_pulses;
        repeat (9) step(0, 0, 4'b0100);
        repeat (4) step(0, 0, 4'b0000);
        check("disabled pulses", dut_pulses - p0, 0);
        check("disabled overflow", 32'(overflow), 0);

        // Nine back-to-back hits while enabled: every one is eventually served.
        p0 = dut_pulses;
        e0 = exp_pulses;
        repeat (9) step(1, 0, 4'b0100);
        repeat (30) step(1, 0, 4'b0000);
        check("burst9 pulses", dut_pulses - p0, exp_pulses - e0);
        check("burst9 busy", 32'(busy), 0);

        // A long burst outruns the drain rate and saturates the counter.
        p0 = dut_pulses;
        e0 = exp_pulses;
        repeat (24) step(1, 0, 4'b0100);
        repeat (60) step(1, 0, 4'b0000);
        check("saturate overflow", 32'(overflow), 32'h4);
        check("saturate pulses", dut_pulses - p0, exp_pulses - e0);

        // Clear during PULSE: pulse not repeated, one score_clr, everything flushed (incl. sticky overflow).
        step(1, 0, 4'b1010);
        step(1, 0, 4'b0000);
        check("pre-clear score_inc", 32'(score_inc), 1);
        step(1, 1, 4'b0000);
        check("clear score_inc", 32'(score_inc), 0);
        check("clear score_clr", 32'(score_clr), 1);
        p0 = dut_pulses;
        repeat (10) step(1, 0, 4'b0000);
        check("after clear pulses", dut_pulses - p0, 0);
        check("after clear overflow", 32'(overflow), 0);
        check("after clear busy", 32'(busy), 0);

        // Asynchronous reset in the middle of GAP with two hits still pending.
        step(1, 0, 4'b0100);
        step(1, 0, 4'b0100);
        step(1, 0, 4'b0100);
        reset = 1'b0;
        #1;
        check("midgap reset score_inc", 32'(score_inc), 0);
        check("midgap reset score_clr", 32'(score_clr), 0);
        check("midgap reset busy", 32'(busy), 0);
        check("midgap reset overflow", 32'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        p0 = dut_pulses;
        repeat (10) step(1, 0, 4'b0000);
        check("post reset pulses", dut_pulses - p0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic       en, clr;
            logic [3:0] hit;
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 59) == 0);
            hit = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            if (n >= 200 && n < 260) hit = 4'($urandom_range(0, 15));
            step(en, clr, hit);
        end
        repeat (80) step(1, 0, 4'b0000);
        check("random total pulses", dut_pulses, exp_pulses);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
